coord_stepper: RTL and testbench
================================

// Module: coord_stepper
// PURPOSE
//  Downstream of the view-parameter stage. Latches centre_x/centre_y/zoom_level once per frame and
//  walks the visible raster in row-major order. Emits one complex-plane coordinate (c_re, c_im) per
//  pixel to the iteration engine over a valid/ready handshake. Uses incremental stepping only; no
//  multipliers.
// PARAMETERS
//  COORD_WIDTH  16    coordinate width, Q4.12 signed (matches view-parameter stage)
//  FRAC_EXT     8     extra fraction bits in internal accumulators (internal Q4.20, ACC_W=24)
//  ZOOM_WIDTH   8     zoom_level width
//  H_RES        640   pixels per row
//  V_RES        480   rows per frame
//  BASE_STEP    4915  per-pixel step at zoom 0, in internal Q4.20 LSBs (~3.0/640)
//  MAX_SHIFT    12    zoom saturation: shift = min(zoom_level, MAX_SHIFT)
// PORTS
//  clk          in   1            system clock
//  rst          in   1            asynchronous, active-high reset
//  frame_start  in   1            1-cycle pulse, asserted the cycle after v_begin (params settled)
//  centre_x     in   COORD_WIDTH  view centre, real axis, Q4.12 signed
//  centre_y     in   COORD_WIDTH  view centre, imaginary axis, Q4.12 signed
//  zoom_level   in   ZOOM_WIDTH   zoom, 0 = widest
//  c_re         out  COORD_WIDTH  pixel real coord, Q4.12 (accumulator >>> FRAC_EXT, floor)
//  c_im         out  COORD_WIDTH  pixel imag coord, Q4.12
//  px_x         out  $clog2(H_RES) pixel column of current coord
//  px_y         out  $clog2(V_RES) pixel row of current coord
//  coord_valid  out  1            c_re/c_im/px_x/px_y valid
//  coord_ready  in   1            consumer accepts when valid&&ready
//  last_pixel   out  1            qualifies coord_valid: px_x==H_RES-1 && px_y==V_RES-1
//  frame_done   out  1            1-cycle pulse after last pixel handshake
// BEHAVIOUR
//  - Reset: state=IDLE; coord_valid=0, frame_done=0, last_pixel=0, c_re=c_im=0, px_x=px_y=0.
//  - States: IDLE -> LOAD (on frame_start) -> RUN -> DONE -> IDLE; DONE lasts 1 cycle, drives frame_done.
//  - LOAD (1 cycle):
//    - sign-extend centre to ACC_W (<<FRAC_EXT); shift=min(zoom_level,MAX_SHIFT); step=BASE_STEP>>shift.
//    - re0=cx_ext-((H_RES/2*BASE_STEP)>>shift); im0=cy_ext+((V_RES/2*BASE_STEP)>>shift) (row 0 = top).
//    - Half-span constants are localparams; computed in ACC_W+8 bits then truncated, no overflow check.
//  - RUN: coord_valid=1 from the cycle after LOAD; outputs held stable while valid&&!ready.
//  - Per handshake:
//    - px_x<H_RES-1: re_acc+=step, px_x++.
//    - else: px_x=0, re_acc=re0, im_acc-=step, px_y++.
//    - Last pixel: ->DONE, coord_valid drops next cycle.
//  - Throughput: one coord per cycle while ready held high; first valid 2 cycles after frame_start.
//  - Params latched only in LOAD; input changes mid-frame ignored.
//  - Accumulators wrap mod 2^ACC_W (two's complement); no saturation.
//  - frame_start in RUN/DONE: abort frame, go to LOAD (coord_valid low for that LOAD cycle);
//    frame_done not pulsed for the aborted frame.
//  - frame_start coincident with final handshake: abort wins, no frame_done.
//  - Reset asserted mid-frame: immediate return to reset values; no frame_done.
// STRUCTURE
//  - Shared package fractal_pkg: COORD_WIDTH, FRAC_EXT, ACC_W, H_RES, V_RES, BASE_STEP, MAX_SHIFT;
//    state enum typedef; coord_t typedef (logic signed [COORD_WIDTH-1:0]).
//  - One sub-module, raster_counter: px_x/px_y counter with advance input, row_wrap and last outputs.
//  - Start-point and step arithmetic stays in this module.
// TESTING
//  1. Reset, then frame_start with centre_x=0xF800, centre_y=0, zoom=0, ready=1:
//     - first coord c_re=0xE000, c_im=0x11FF, px=(0,0).
//     - second coord c_re=0xE013.
//  2. Hold ready=1 for a full frame:
//     - exactly 307200 handshakes; last_pixel only on (639,479); frame_done pulses once, 1 cycle later.
//     - Row 1 starts at c_re=0xE000; c_im equals (im0-4915)>>>8.
//  3. Backpressure:
//     - ready low 5 cycles mid-row: outputs frozen, no px skipped or repeated.
//     - ready toggling 1/0: output sequence identical to test 2.
//  4. zoom=200 (saturates at 12):
//     - step=1; c_re of pixel 0 = (cx_ext-383)>>>8.
//     - centre 0 gives c_re=0xFFFE (floor(-383/256)=-2).
//  5. Mid-frame frame_start, new centre_x=0x1000:
//     - no frame_done; next valid coord is px=(0,0) computed from new params.
//  6. rst pulse at px=(100,50): valid drops asynchronously; IDLE until next frame_start.

Source files
------------

// File: rtl/fractal_pkg.sv
// Shared constants and types for the fractal coordinate pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fractal_pkg;

  localparam int COORD_WIDTH = 16;                     // Q4.12 signed
  localparam int FRAC_EXT    = 8;                      // extra accumulator fraction bits
  localparam int ACC_W       = COORD_WIDTH + FRAC_EXT; // Q4.20 accumulators
  localparam int ZOOM_WIDTH  = 8;
  localparam int H_RES       = 640;
  localparam int V_RES       = 480;
  localparam int BASE_STEP   = 4915;                   // ~3.0/640 in Q4.20 LSBs
  localparam int MAX_SHIFT   = 12;
  localparam int SHIFT_W     = $clog2(MAX_SHIFT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  typedef logic signed [COORD_WIDTH-1:0] coord_t;

  // Zoom level saturated to the deepest supported step shift.
  function automatic logic [SHIFT_W-1:0] zoom_shift(input logic [ZOOM_WIDTH-1:0] zoom);
    if (zoom > ZOOM_WIDTH'(MAX_SHIFT))
      return SHIFT_W'(MAX_SHIFT);
    return SHIFT_W'(zoom);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row-major pixel counter: px_x runs 0..H_RES-1, then px_y advances; wraps to (0,0) after the last pixel.
// Latency: position updates on the clock edge where advance is high.
// Backpressure: holds position while advance is low.
// Ports: clk, rst (async, active-high), clear (sync return to origin), advance,
//        px_x/px_y (current position), row_wrap (px_x at last column), last (final pixel of frame).
module raster_counter import fractal_pkg::*; #(
  parameter int H_RES = fractal_pkg::H_RES,
  parameter int V_RES = fractal_pkg::V_RES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     advance,
  output logic [$clog2(H_RES)-1:0] px_x,
  output logic [$clog2(V_RES)-1:0] px_y,
  output logic                     row_wrap,
  output logic                     last
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);

  assign row_wrap = (px_x == XW'(H_RES - 1));
  assign last     = row_wrap && (px_y == YW'(V_RES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_x <= '0;
      px_y <= '0;
    end else if (clear) begin
      px_x <= '0;
      px_y <= '0;
    end else if (advance) begin
      if (row_wrap) begin
        px_x <= '0;
        px_y <= last ? '0 : px_y + 1'b1;
      end else begin
        px_x <= px_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coord_stepper.sv
// Walks the visible raster row-major, emitting one complex-plane coordinate per pixel by stepping.
// Latency: first coord_valid 2 cycles after frame_start; then one coord per cycle while ready.
// Backpressure: valid/ready; all outputs hold while coord_valid && !coord_ready.
// Ports: clk, rst (async, active-high); frame_start, centre_x/centre_y (Q4.12), zoom_level in;
//        c_re/c_im (Q4.12), px_x/px_y, coord_valid, last_pixel, frame_done out; coord_ready in.
module coord_stepper import fractal_pkg::*; #(
  parameter int H_RES = fractal_pkg::H_RES,
  parameter int V_RES = fractal_pkg::V_RES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [COORD_WIDTH-1:0]   centre_x,
  input  logic [COORD_WIDTH-1:0]   centre_y,
  input  logic [ZOOM_WIDTH-1:0]    zoom_level,
  output coord_t                   c_re,
  output coord_t                   c_im,
  output logic [$clog2(H_RES)-1:0] px_x,
  output logic [$clog2(V_RES)-1:0] px_y,
  output logic                     coord_valid,
  input  logic                     coord_ready,
  output logic                     last_pixel,
  output logic                     frame_done
);

  // Half the visible span at zoom 0; 8 guard bits so the products never overflow before shifting.
  localparam logic [ACC_W+7:0] HALF_RE = (ACC_W+8)'(H_RES / 2 * BASE_STEP);
  localparam logic [ACC_W+7:0] HALF_IM = (ACC_W+8)'(V_RES / 2 * BASE_STEP);

  state_t             state;
  logic [ACC_W-1:0]   re_acc, im_acc, re0, step;
  logic [ACC_W-1:0]   cx_ext, cy_ext, step_n, re0_n, im0_n;
  logic [SHIFT_W-1:0] shift;
  logic               hs, advance, row_wrap, last;

  // COORD_WIDTH + FRAC_EXT == ACC_W, so appending zeros is the sign-extended left shift.
  assign cx_ext = {centre_x, {FRAC_EXT{1'b0}}};
  assign cy_ext = {centre_y, {FRAC_EXT{1'b0}}};
  assign shift  = zoom_shift(zoom_level);
  assign step_n = ACC_W'(BASE_STEP) >> shift;
  assign re0_n  = cx_ext - ACC_W'(HALF_RE >> shift);
  assign im0_n  = cy_ext + ACC_W'(HALF_IM >> shift);  // row 0 is the top of the view

  assign hs = coord_valid && coord_ready;
  // A restart request wins over a handshake in the same cycle.
  assign advance = hs && !frame_start;

  // Dropping FRAC_EXT LSBs of a two's-complement value is a floor toward -inf.
  assign c_re       = coord_t'(re_acc[ACC_W-1:FRAC_EXT]);
  assign c_im       = coord_t'(im_acc[ACC_W-1:FRAC_EXT]);
  assign last_pixel = coord_valid && last;

  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_raster (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == LOAD),
    .advance  (advance),
    .px_x     (px_x),
    .px_y     (px_y),
    .row_wrap (row_wrap),
    .last     (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      coord_valid <= 1'b0;
      frame_done  <= 1'b0;
      re_acc      <= '0;
      im_acc      <= '0;
      re0         <= '0;
      step        <= '0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        // Any state restarts; an in-flight frame is dropped without frame_done.
        state       <= LOAD;
        coord_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            step        <= step_n;
            re0         <= re0_n;
            re_acc      <= re0_n;
            im_acc      <= im0_n;
            coord_valid <= 1'b1;
            state       <= RUN;
          end
          RUN: begin
            if (hs) begin
              if (last) begin
                coord_valid <= 1'b0;
                frame_done  <= 1'b1;
                state       <= DONE;
              end else if (row_wrap) begin
                re_acc <= re0;
                im_acc <= im_acc - step;
              end else begin
                re_acc <= re_acc + step;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coord_stepper.sv
// Directed bench: a full-size instance for coordinate values, abort, zoom and reset,
// plus an 8x4 instance for whole-frame, backpressure and final-handshake abort cases.
module tb_coord_stepper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] centre_x, centre_y;
  logic [7:0]  zoom;
  logic        fs_l, rdy_l, fs_s, rdy_s;

  logic [15:0] l_re, l_im, s_re, s_im;
  logic [9:0]  l_px;
  logic [8:0]  l_py;
  logic [2:0]  s_px;
  logic [1:0]  s_py;
  logic        l_vld, l_last, l_fd, s_vld, s_last, s_fd;

  int n_vec = 0;
  int n_err = 0;
  int l_fd_cnt = 0;

  // 8x4 raster at zoom 0, centre (-0.5, 0): start points in Q4.20.
  localparam int STEP0 = 4915;
  localparam int S_RE0 = -524288 - 4 * 4915;
  localparam int S_IM0 = 2 * 4915;

  coord_stepper dut_l (
    .clk(clk), .rst(rst), .frame_start(fs_l),
    .centre_x(centre_x), .centre_y(centre_y), .zoom_level(zoom),
    .c_re(l_re), .c_im(l_im), .px_x(l_px), .px_y(l_py),
    .coord_valid(l_vld), .coord_ready(rdy_l), .last_pixel(l_last), .frame_done(l_fd)
  );

  coord_stepper #(.H_RES(8), .V_RES(4)) dut_s (
    .clk(clk), .rst(rst), .frame_start(fs_s),
    .centre_x(centre_x), .centre_y(centre_y), .zoom_level(zoom),
    .c_re(s_re), .c_im(s_im), .px_x(s_px), .px_y(s_py),
    .coord_valid(s_vld), .coord_ready(rdy_s), .last_pixel(s_last), .frame_done(s_fd)
  );

  always @(posedge clk) if (l_fd) l_fd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] s_exp_re(input int x);
    int v;
    v = (S_RE0 + x * STEP0) >>> 8;
    return v[15:0];
  endfunction

  function automatic logic [15:0] s_exp_im(input int y);
    int v;
    v = (S_IM0 - y * STEP0) >>> 8;
    return v[15:0];
  endfunction

  // Starts a frame on the large instance; leaves us at the negedge where pixel 0 is shown.
  task automatic l_start(input string tag);
    fs_l = 1'b1;
    @(negedge clk);
    fs_l = 1'b0;
    chk({tag, " load_vld"}, 32'(l_vld), 0);
    @(negedge clk);
    chk({tag, " vld"}, 32'(l_vld), 1);
    chk({tag, " px0"}, {l_py, l_px}, 0);
  endtask

  // pat: 0 ready always high, 1 ready toggling, 2 ready low for 5 cycles mid-row.
  task automatic run_frame_s(input string tag, input int pat, input bit abort_last);
    int   idx = 0, cyc = 0, last_cyc = -100, mism = 0;
    int   fd_cnt = 0, fd_cyc = -1, first_vld = -1, stalls = 0, lastp = 0;
    logic r;
    fs_s  = 1'b1;
    rdy_s = 1'b1;
    while (cyc < 300 && !(idx == 32 && cyc >= last_cyc + 2)) begin
      @(negedge clk);
      cyc++;
      fs_s = 1'b0;
      case (pat)
        1:       r = cyc[0];
        2:       r = !(cyc >= 6 && cyc <= 10);
        default: r = 1'b1;
      endcase
      rdy_s = r;
      if (s_fd) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (s_vld && first_vld < 0) first_vld = cyc;
      if (s_vld && idx < 32) begin
        if (s_px != 3'(idx % 8) || s_py != 2'(idx / 8) ||
            s_re != s_exp_re(idx % 8) || s_im != s_exp_im(idx / 8)) mism++;
        if (s_last != (idx == 31)) mism++;
        if (!r) stalls++;
        if (r) begin
          if (s_last) lastp++;
          idx++;
          if (idx == 32) begin
            last_cyc = cyc;
            if (abort_last) fs_s = 1'b1;
          end
        end
      end else if (s_last && !s_vld) begin
        mism++;
      end
    end
    chk({tag, " hs_count"}, idx, 32);
    chk({tag, " seq_errs"}, mism, 0);
    chk({tag, " first_valid_cyc"}, first_vld, 2);
    chk({tag, " last_pixel_hs"}, lastp, 1);
    if (pat == 2) chk({tag, " stall_cycles"}, stalls, 5);
    if (abort_last) begin
      chk({tag, " no_frame_done"}, fd_cnt, 0);
      chk({tag, " restart_vld"}, 32'(s_vld), 1);
      chk({tag, " restart_px"}, {s_py, s_px}, 0);
      chk({tag, " restart_re"}, s_re, s_exp_re(0));
    end else begin
      chk({tag, " frame_done_cnt"}, fd_cnt, 1);
      chk({tag, " frame_done_lat"}, fd_cyc - last_cyc, 1);
      chk({tag, " vld_after"}, 32'(s_vld), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int vld_seen;
    rst = 1'b1;
    fs_l = 1'b0; rdy_l = 1'b0; fs_s = 1'b0; rdy_s = 1'b0;
    centre_x = 16'h0000; centre_y = 16'h0000; zoom = 8'd0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst vld", 32'(l_vld), 0);
    chk("rst frame_done", 32'(l_fd), 0);
    chk("rst last_pixel", 32'(l_last), 0);
    chk("rst c_re_c_im", {l_re, l_im}, 0);
    chk("rst px", {l_py, l_px}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle vld", 32'(l_vld), 0);

    // First coordinates at zoom 0, centre (-0.5, 0).
    centre_x = 16'hF800;
    rdy_l = 1'b1;
    l_start("t1");
    chk("t1 c_re0", l_re, 16'hE000);
    chk("t1 c_im0", l_im, 16'h11FF);
    @(negedge clk);
    chk("t1 c_re1", l_re, 16'hE013);
    chk("t1 px1", {l_py, l_px}, 1);

    // Row 1 restarts at re0 and steps the imaginary axis down by one step.
    k = 0;
    while (l_py != 9'd1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("t2 row1 reached", 32'(l_py), 1);
    chk("t2 row1 px_x", 32'(l_px), 0);
    chk("t2 row1 c_re", l_re, 16'hE000);
    chk("t2 row1 c_im", l_im, 16'h11EC);

    // Mid-frame restart with a new centre.
    centre_x = 16'h1000;
    l_start("t5");
    chk("t5 c_re", l_re, 16'hF800);
    chk("t5 c_im", l_im, 16'h11FF);
    chk("t5 no_frame_done", l_fd_cnt, 0);

    // Zoom saturates at shift 12: step 1, half span 383 LSBs.
    centre_x = 16'h0000;
    zoom = 8'd200;
    l_start("t4a");
    chk("t4a c_re", l_re, 16'hFFFE);
    chk("t4a c_im", l_im, 16'h0001);
    centre_x = 16'h1000;
    l_start("t4b");
    chk("t4b c_re", l_re, 16'h0FFE);
    repeat (126) @(negedge clk);
    chk("t4b px126", 32'(l_px), 126);
    chk("t4b c_re126", l_re, 16'h0FFE);
    @(negedge clk);
    chk("t4b c_re127", l_re, 16'h0FFF);

    // Reset mid-frame at (100,50).
    centre_x = 16'hF800;
    zoom = 8'd0;
    l_start("t6");
    k = 0;
    while (!(l_px == 10'd100 && l_py == 9'd50) && k < 40000) begin
      @(negedge clk);
      k++;
    end
    chk("t6 reached_100_50", {l_py, l_px}, {9'd50, 10'd100});
    rdy_l = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6 async vld", 32'(l_vld), 0);
    chk("t6 async px", {l_py, l_px}, 0);
    chk("t6 async c_re", l_re, 0);
    #1 rst = 1'b0;
    vld_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (l_vld) vld_seen++;
    end
    chk("t6 idle_after_rst", vld_seen, 0);
    chk("t6 no_frame_done", l_fd_cnt, 0);
    rdy_l = 1'b1;
    l_start("t6r");
    chk("t6r c_re", l_re, 16'hE000);
    rdy_l = 1'b0;

    // Whole frames on the 8x4 instance.
    centre_x = 16'hF800;
    centre_y = 16'h0000;
    zoom = 8'd0;
    run_frame_s("t2s full", 0, 1'b0);
    run_frame_s("t3 stall", 2, 1'b0);
    run_frame_s("t3 toggle", 1, 1'b0);
    run_frame_s("t5 abort_last", 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
